// File: rtl/ysyx_2022040010_ifu_fq_pkg.sv
// Shared constants for the fetch-queue IF stage: reset fetch base, instruction
// step and the pointer-width helper used by the top and its queue storage.
package ysyx_2022040010_ifu_fq_pkg;

    // First fetch address after reset (memory base of the target SoC).
    localparam logic [63:0] PC_MBASE   = 64'h0000_0000_8000_0000;

    // Sequential fetch advances by one 32-bit instruction.
    localparam int          INST_BYTES = 4;

    // Queue pointers carry one extra wrap bit so full and empty are distinct.
    function automatic int fq_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ysyx_2022040010_ifu_fq_if.sv
// Fetch-unit bus bundle: instruction SRAM request/response channel plus the
// IF->ID valid/ready channel. master = fetch unit, slave = SRAM/ID side.
interface ysyx_2022040010_ifu_fq_if #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
);
    // SRAM request channel
    logic              req_valid;
    logic              req_ready;
    logic [PC_W-1:0]   req_addr;
    // SRAM in-order response (always accepted)
    logic              rsp_valid;
    logic [INST_W-1:0] rsp_inst;
    // IF -> ID channel
    logic              id_valid;
    logic              id_ready;
    logic [PC_W-1:0]   id_pc;
    logic [INST_W-1:0] id_inst;

    modport master (
        output req_valid, req_addr, id_valid, id_pc, id_inst,
        input  req_ready, rsp_valid, rsp_inst, id_ready
    );

    modport slave (
        input  req_valid, req_addr, id_valid, id_pc, id_inst,
        output req_ready, rsp_valid, rsp_inst, id_ready
    );
endinterface

// File: rtl/ysyx_2022040010_fq_ram.sv
// Fetch-queue storage: DEPTH entries of {pc, inst}. The pc half is written
// when a request is issued, the inst half when its response returns, so the
// two halves have independent write ports. Read is asynchronous so the head
// entry is visible to ID in the same cycle the pointer moves onto it.
module ysyx_2022040010_fq_ram #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INST_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              pc_we,
    input  logic [AW-1:0]     pc_waddr,
    input  logic [PC_W-1:0]   pc_wdata,
    input  logic              inst_we,
    input  logic [AW-1:0]     inst_waddr,
    input  logic [INST_W-1:0] inst_wdata,
    input  logic [AW-1:0]     raddr,
    output logic [PC_W-1:0]   rd_pc,
    output logic [INST_W-1:0] rd_inst
);
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    // Record the PC of a newly allocated entry.
    always_ff @(posedge clk) begin
        if (pc_we) begin
            pc_mem[pc_waddr] <= pc_wdata;
        end
    end

    // Fill the instruction of the oldest unfilled entry.
    always_ff @(posedge clk) begin
        if (inst_we) begin
            inst_mem[inst_waddr] <= inst_wdata;
        end
    end

    assign rd_pc   = pc_mem[raddr];
    assign rd_inst = inst_mem[raddr];
endmodule

// File: rtl/ysyx_2022040010_ifu_fq.sv
// IF stage with fetch queue: issues sequential fetches, keeps up to FQ_DEPTH
// requests outstanding or buffered, pairs in-order responses with their PCs
// and hands them to ID. A redirect flushes the queue and counts the in-flight
// responses that must be thrown away (drop_cnt).
// Optional: define YSYX_IFU_PERF_EN to add perf_fetch/perf_flush/perf_stall.
module ysyx_2022040010_ifu_fq
    import ysyx_2022040010_ifu_fq_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(PC_MBASE),
    parameter int              FQ_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_e,
    input  logic [PC_W-1:0]      br_addr,
    ysyx_2022040010_ifu_fq_if.master bus
`ifdef YSYX_IFU_PERF_EN
    ,
    output logic [63:0]          perf_fetch,
    output logic [31:0]          perf_flush,
    output logic [63:0]          perf_stall
`endif
);
    localparam int              PTR_W  = fq_ptr_w(FQ_DEPTH);
    localparam int              AW     = PTR_W - 1;
    localparam logic [PTR_W:0]  FQ_CAP = (PTR_W + 1)'(FQ_DEPTH);

    // wptr: allocation (request issued), fptr: fill (response stored),
    // rptr: read (consumed by ID). Entries [rptr,fptr) are ready for ID,
    // [fptr,wptr) are waiting on the SRAM.
    logic [PC_W-1:0]  pc_reg,       pc_next;
    logic [PTR_W-1:0] wptr_reg,     wptr_next;
    logic [PTR_W-1:0] fptr_reg,     fptr_next;
    logic [PTR_W-1:0] rptr_reg,     rptr_next;
    logic [PTR_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic             started_reg;

    logic [PTR_W-1:0] occ;
    logic [PTR_W-1:0] in_flight;
    logic [PTR_W:0]   budget;
    logic             req_valid;
    logic             req_fire;
    logic             rsp_fill;
    logic             rsp_drop;
    logic             id_valid;
    logic             id_fire;
    logic [PC_W-1:0]  rd_pc;
    logic [INST_W-1:0] rd_inst;

    // Stale responses still owed by the SRAM occupy queue slots too, so they
    // count against the budget until they have been drained.
    assign occ       = wptr_reg - rptr_reg;
    assign in_flight = wptr_reg - fptr_reg;
    assign budget    = {1'b0, occ} + {1'b0, drop_cnt_reg};

    assign req_valid = ~rst & started_reg & ~br_e & (budget < FQ_CAP);
    assign req_fire  = req_valid & bus.req_ready;
    assign rsp_fill  = bus.rsp_valid & ~br_e & (drop_cnt_reg == '0);
    assign rsp_drop  = bus.rsp_valid & ~br_e & (drop_cnt_reg != '0);
    assign id_valid  = ~rst & (fptr_reg != rptr_reg);
    assign id_fire   = id_valid & bus.id_ready;

    assign bus.req_valid = req_valid;
    assign bus.req_addr  = pc_reg;
    assign bus.id_valid  = id_valid;
    assign bus.id_pc     = rd_pc;
    assign bus.id_inst   = rd_inst;

    // Next-state for PC, queue pointers and drop counter; redirect wins.
    always_comb begin
        pc_next       = pc_reg;
        wptr_next     = wptr_reg;
        fptr_next     = fptr_reg;
        rptr_next     = rptr_reg;
        drop_cnt_next = drop_cnt_reg;
        if (br_e) begin
            // Everything issued but not yet filled becomes a drop; a response
            // arriving in this very cycle is one of those and is consumed now.
            pc_next       = br_addr;
            wptr_next     = '0;
            fptr_next     = '0;
            rptr_next     = '0;
            drop_cnt_next = drop_cnt_reg + in_flight - PTR_W'(bus.rsp_valid);
        end else begin
            if (req_fire) begin
                wptr_next = wptr_reg + PTR_W'(1);
                pc_next   = pc_reg + PC_W'(INST_BYTES);
            end
            if (rsp_fill) begin
                fptr_next = fptr_reg + PTR_W'(1);
            end
            if (rsp_drop) begin
                drop_cnt_next = drop_cnt_reg - PTR_W'(1);
            end
            if (id_fire) begin
                rptr_next = rptr_reg + PTR_W'(1);
            end
        end
    end

    // State registers; started_reg holds requests off for one cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            wptr_reg     <= '0;
            fptr_reg     <= '0;
            rptr_reg     <= '0;
            drop_cnt_reg <= '0;
            started_reg  <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            wptr_reg     <= wptr_next;
            fptr_reg     <= fptr_next;
            rptr_reg     <= rptr_next;
            drop_cnt_reg <= drop_cnt_next;
            started_reg  <= 1'b1;
        end
    end

    ysyx_2022040010_fq_ram #(
        .DEPTH  (FQ_DEPTH),
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_fq_ram (
        .clk        (clk),
        .pc_we      (req_fire),
        .pc_waddr   (wptr_reg[AW-1:0]),
        .pc_wdata   (pc_reg),
        .inst_we    (rsp_fill),
        .inst_waddr (fptr_reg[AW-1:0]),
        .inst_wdata (bus.rsp_inst),
        .raddr      (rptr_reg[AW-1:0]),
        .rd_pc      (rd_pc),
        .rd_inst    (rd_inst)
    );

`ifdef YSYX_IFU_PERF_EN
    // Free-running event counters: fetches issued, redirects, ID-starved cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch <= '0;
            perf_flush <= '0;
            perf_stall <= '0;
        end else begin
            if (req_fire) begin
                perf_fetch <= perf_fetch + 64'd1;
            end
            if (br_e) begin
                perf_flush <= perf_flush + 32'd1;
            end
            if (started_reg && !id_valid) begin
                perf_stall <= perf_stall + 64'd1;
            end
        end
    end
`endif

endmodule
